// File: rtl/clock_time_counter.sv
// Seconds/minutes/hours counters driven by synchronized increment strobes, with wrap pulses and BCD views.
// Define CLOCK_HOUR12_EN for a 12-hour o_hour display and a live o_pm flag (hour24 still counts 0..23).
module clock_time_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sec_clk,
  input  logic       i_min_clk,
  input  logic       i_hour_clk,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic [7:0] o_sec_bcd,
  output logic [7:0] o_min_bcd,
  output logic [7:0] o_hour_bcd,
  output logic       o_max_hit_sec,
  output logic       o_max_hit_min,
  output logic       o_max_hit_hour,
  output logic       o_pm
);

  localparam logic [5:0] SecMax  = 6'd59;
  localparam logic [5:0] MinMax  = 6'd59;
  localparam logic [4:0] HourMax = 5'd23;

  logic [2:0] in_vec;
  logic [2:0] s1_q, s1_d;
  logic [2:0] s2_q, s2_d;
  logic [2:0] s3_q, s3_d;
  logic       load_q, load_d;
  logic [2:0] rise;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour24_q, hour24_d;
  logic [2:0] max_hit_q, max_hit_d;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    to_bcd = {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  assign in_vec = {i_hour_clk, i_min_clk, i_sec_clk};

  // First cycle after reset: load the live input everywhere so a held-high strobe is not a rise.
  always_comb begin
    load_d = 1'b0;
    s1_d   = in_vec;
    s2_d   = s1_q;
    s3_d   = s2_q;
    if (load_q) begin
      s2_d = in_vec;
      s3_d = in_vec;
    end
  end

  assign rise = s2_q & ~s3_q;

  always_comb begin
    sec_d     = sec_q;
    min_d     = min_q;
    hour24_d  = hour24_q;
    max_hit_d = 3'b000;
    if (rise[0]) begin
      if (sec_q == SecMax) begin
        sec_d        = 6'd0;
        max_hit_d[0] = 1'b1;
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
    if (rise[1]) begin
      if (min_q == MinMax) begin
        min_d        = 6'd0;
        max_hit_d[1] = 1'b1;
      end else begin
        min_d = min_q + 6'd1;
      end
    end
    if (rise[2]) begin
      if (hour24_q == HourMax) begin
        hour24_d     = 5'd0;
        max_hit_d[2] = 1'b1;
      end else begin
        hour24_d = hour24_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_q    <= 1'b1;
      s1_q      <= 3'b000;
      s2_q      <= 3'b000;
      s3_q      <= 3'b000;
      sec_q     <= 6'd0;
      min_q     <= 6'd0;
      hour24_q  <= 5'd0;
      max_hit_q <= 3'b000;
    end else begin
      load_q    <= load_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour24_q  <= hour24_d;
      max_hit_q <= max_hit_d;
    end
  end

  assign o_sec          = sec_q;
  assign o_min          = min_q;
  assign o_max_hit_sec  = max_hit_q[0];
  assign o_max_hit_min  = max_hit_q[1];
  assign o_max_hit_hour = max_hit_q[2];

`ifdef CLOCK_HOUR12_EN
  logic [4:0] hour_disp_q, hour_disp_d;
  logic       pm_q, pm_d;

  // Display hour is registered from the next hour24 so it stays aligned with the counters.
  always_comb begin
    pm_d        = (hour24_d >= 5'd12);
    hour_disp_d = pm_d ? (hour24_d - 5'd12) : hour24_d;
    if (hour_disp_d == 5'd0) begin
      hour_disp_d = 5'd12;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hour_disp_q <= 5'd12;
      pm_q        <= 1'b0;
    end else begin
      hour_disp_q <= hour_disp_d;
      pm_q        <= pm_d;
    end
  end

  assign o_hour = hour_disp_q;
  assign o_pm   = pm_q;
`else
  assign o_hour = hour24_q;
  assign o_pm   = 1'b0;
`endif

  assign o_sec_bcd  = to_bcd(sec_q);
  assign o_min_bcd  = to_bcd(min_q);
  assign o_hour_bcd = to_bcd({1'b0, o_hour});

endmodule

// File: tb/tb_clock_time_counter.sv
// Self-checking bench for clock_time_counter: directed scenarios plus randomized strobes against a
// behavioural time-keeping model; honours CLOCK_HOUR12_EN for the hour display expectations.
module tb_clock_time_counter;

  logic       clk;
  logic       rst_n;
  logic       sec_drv, min_drv, hour_drv, loop_en;
  logic       i_sec_clk, i_min_clk, i_hour_clk;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hour;
  logic [7:0] o_sec_bcd, o_min_bcd, o_hour_bcd;
  logic       o_max_hit_sec, o_max_hit_min, o_max_hit_hour, o_pm;

  int check_count = 0;
  int pass_count  = 0;
  int hit_sec_seen = 0;
  int hit_min_seen = 0;

  // Model state: counts, wrap flags and the rise events still travelling through the 2-cycle latency.
  int         m_cnt [3];
  int         m_max [3] = '{59, 59, 23};
  logic [2:0] m_hit, m_pend1, m_pend2, m_prev, m_smp;
  bit         m_fresh = 1'b1;
  bit         m_valid = 1'b0;

  assign i_sec_clk  = sec_drv;
  assign i_min_clk  = loop_en ? o_max_hit_sec : min_drv;
  assign i_hour_clk = loop_en ? o_max_hit_min : hour_drv;

  clock_time_counter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_sec_clk     (i_sec_clk),
    .i_min_clk     (i_min_clk),
    .i_hour_clk    (i_hour_clk),
    .o_sec         (o_sec),
    .o_min         (o_min),
    .o_hour        (o_hour),
    .o_sec_bcd     (o_sec_bcd),
    .o_min_bcd     (o_min_bcd),
    .o_hour_bcd    (o_hour_bcd),
    .o_max_hit_sec (o_max_hit_sec),
    .o_max_hit_min (o_max_hit_min),
    .o_max_hit_hour(o_max_hit_hour),
    .o_pm          (o_pm)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic int exp_hour(input int h);
`ifdef CLOCK_HOUR12_EN
    return (h % 12 == 0) ? 12 : h % 12;
`else
    return h;
`endif
  endfunction

  function automatic int exp_pm(input int h);
`ifdef CLOCK_HOUR12_EN
    return (h >= 12) ? 1 : 0;
`else
    return 0 * h;
`endif
  endfunction

  function automatic int bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic [2:0] mask, input int hi, input int lo);
    sec_drv  = mask[0];
    min_drv  = mask[1];
    hour_drv = mask[2];
    repeat (hi) @(negedge clk);
    sec_drv  = 1'b0;
    min_drv  = 1'b0;
    hour_drv = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic doReset();
    sec_drv  = 1'b0;
    min_drv  = 1'b0;
    hour_drv = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Model: a rise seen at one edge updates the count two edges later; a held-high input at release is ignored.
  always @(posedge clk) begin
    m_smp = {loop_en ? m_hit[1] : hour_drv, loop_en ? m_hit[0] : min_drv, sec_drv};
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_hit   = 3'b000;
      m_pend1 = 3'b000;
      m_pend2 = 3'b000;
      m_prev  = 3'b000;
      m_fresh = 1'b1;
      m_valid = 1'b1;
    end else begin
      m_hit = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (m_pend2[i]) begin
          m_cnt[i] = (m_cnt[i] + 1) % (m_max[i] + 1);
          m_hit[i] = (m_cnt[i] == 0);
        end
      end
      m_pend2 = m_pend1;
      m_pend1 = m_fresh ? 3'b000 : (m_smp & ~m_prev);
      m_prev  = m_smp;
      m_fresh = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("cmp_sec", o_sec, m_cnt[0]);
      checkOutput("cmp_min", o_min, m_cnt[1]);
      checkOutput("cmp_hour", o_hour, exp_hour(m_cnt[2]));
      checkOutput("cmp_pm", o_pm, exp_pm(m_cnt[2]));
      checkOutput("cmp_sec_bcd", o_sec_bcd, bcd(m_cnt[0]));
      checkOutput("cmp_min_bcd", o_min_bcd, bcd(m_cnt[1]));
      checkOutput("cmp_hour_bcd", o_hour_bcd, bcd(exp_hour(m_cnt[2])));
      checkOutput("cmp_hits", {o_max_hit_hour, o_max_hit_min, o_max_hit_sec}, m_hit);
      if (o_max_hit_sec === 1'b1) hit_sec_seen++;
      if (o_max_hit_min === 1'b1) hit_min_seen++;
    end
  end

  initial begin
    int snap;
    rst_n = 1'b0; sec_drv = 1'b0; min_drv = 1'b0; hour_drv = 1'b0; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sec", o_sec, 0);
    checkOutput("reset_min", o_min, 0);
`ifdef CLOCK_HOUR12_EN
    checkOutput("reset_hour", o_hour, 12);
`else
    checkOutput("reset_hour", o_hour, 0);
`endif
    checkOutput("reset_pm", o_pm, 0);
    checkOutput("reset_hits", {o_max_hit_hour, o_max_hit_min, o_max_hit_sec}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    snap = hit_sec_seen;
    repeat (59) applyStimulus(3'b001, 2, 2);
    repeat (3) @(negedge clk);
    checkOutput("sec59", o_sec, 59);
    checkOutput("sec59_bcd", o_sec_bcd, 8'h59);
    checkOutput("sec59_no_hit", hit_sec_seen - snap, 0);
    sec_drv = 1'b1;
    @(negedge clk);
    checkOutput("wrap_e1_hit", o_max_hit_sec, 0);
    @(negedge clk);
    checkOutput("wrap_e2_sec", o_sec, 59);
    @(negedge clk);
    checkOutput("wrap_e3_sec", o_sec, 0);
    checkOutput("wrap_e3_hit", o_max_hit_sec, 1);
    sec_drv = 1'b0;
    @(negedge clk);
    checkOutput("wrap_e4_hit", o_max_hit_sec, 0);
    repeat (2) @(negedge clk);

    doReset();
    repeat (23) applyStimulus(3'b110, 2, 2);
    repeat (36) applyStimulus(3'b010, 2, 2);
    repeat (3) @(negedge clk);
    checkOutput("preset_min", o_min, 59);
    checkOutput("preset_hour", o_hour, exp_hour(23));
    min_drv = 1'b1; hour_drv = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("dual_wrap_min", o_min, 0);
    checkOutput("dual_wrap_hour", o_hour, exp_hour(0));
    checkOutput("dual_wrap_hits", {o_max_hit_hour, o_max_hit_min}, 2'b11);
    min_drv = 1'b0; hour_drv = 1'b0;
    repeat (2) @(negedge clk);

    sec_drv = 1'b1; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("held_high_no_inc", o_sec, 0);
    sec_drv = 1'b0;
    repeat (2) @(negedge clk);
    sec_drv = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("held_high_then_rise", o_sec, 1);
    sec_drv = 1'b0;
    repeat (2) @(negedge clk);

    doReset();
    repeat (37) applyStimulus(3'b011, 2, 2);
    repeat (3) @(negedge clk);
    checkOutput("pre_abort_sec", o_sec, 37);
    sec_drv = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_sec", o_sec, 0);
    checkOutput("abort_min", o_min, 0);
    checkOutput("abort_hits", {o_max_hit_hour, o_max_hit_min, o_max_hit_sec}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("abort_no_late_inc", o_sec, 0);
    sec_drv = 1'b0;
    repeat (2) @(negedge clk);

    doReset();
    repeat (13) applyStimulus(3'b100, 2, 2);
    repeat (3) @(negedge clk);
`ifdef CLOCK_HOUR12_EN
    checkOutput("h13_hour", o_hour, 1);
    checkOutput("h13_pm", o_pm, 1);
    checkOutput("h13_bcd", o_hour_bcd, 8'h01);
`else
    checkOutput("h13_hour", o_hour, 13);
    checkOutput("h13_pm", o_pm, 0);
    checkOutput("h13_bcd", o_hour_bcd, 8'h13);
`endif
    repeat (11) applyStimulus(3'b100, 2, 2);
    repeat (3) @(negedge clk);
`ifdef CLOCK_HOUR12_EN
    checkOutput("h0_hour", o_hour, 12);
    checkOutput("h0_bcd", o_hour_bcd, 8'h12);
`else
    checkOutput("h0_hour", o_hour, 0);
    checkOutput("h0_bcd", o_hour_bcd, 8'h00);
`endif
    checkOutput("h0_pm", o_pm, 0);

    doReset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) == 0) doReset();
      applyStimulus(3'($urandom_range(0, 7)), $urandom_range(2, 3), $urandom_range(2, 4));
    end
    repeat (4) @(negedge clk);

    doReset();
    loop_en = 1'b1;
    snap = hit_min_seen;
    repeat (3600) applyStimulus(3'b001, 2, 2);
    repeat (12) @(negedge clk);
    checkOutput("loop_sec", o_sec, 0);
    checkOutput("loop_min", o_min, 0);
    checkOutput("loop_hour", o_hour, 1);
    checkOutput("loop_min_wraps", hit_min_seen - snap, 1);
    loop_en = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
